// File: rtl/cla_seq_ctrl_if.sv
// cla_seq_ctrl_if
//   Handshake, operand/result bus and external-adder hookup for cla_seq_ctrl.
//   Parameter WORDS : number of 16-bit words per operand (1..8).
//   Requester side : Start, A_In, B_In, C_In (and Op when CLA_SEQ_SUB_EN is
//                    defined) in; Ready, Busy, Done, Sum_Out, C_Out out.
//   Adder side     : Add_A, Add_B, Add_Cin out to a 16-bit combinational
//                    adder; Add_Sum, Add_Cout back in the same cycle.
//   Modports: slave = the controller, master = requester plus adder.
//   Optional macro: CLA_SEQ_SUB_EN adds the Op signal (0 = add, 1 = subtract).
interface cla_seq_ctrl_if #(
    parameter int WORDS = 4
);
    logic                  Start;
    logic [16*WORDS-1:0]   A_In;
    logic [16*WORDS-1:0]   B_In;
    logic                  C_In;
`ifdef CLA_SEQ_SUB_EN
    logic                  Op;
`endif
    logic                  Ready;
    logic                  Busy;
    logic                  Done;
    logic [16*WORDS-1:0]   Sum_Out;
    logic                  C_Out;
    logic [15:0]           Add_A;
    logic [15:0]           Add_B;
    logic                  Add_Cin;
    logic [15:0]           Add_Sum;
    logic                  Add_Cout;

    modport slave (
        input  Start, A_In, B_In, C_In,
`ifdef CLA_SEQ_SUB_EN
        input  Op,
`endif
        input  Add_Sum, Add_Cout,
        output Ready, Busy, Done, Sum_Out, C_Out,
        output Add_A, Add_B, Add_Cin
    );

    modport master (
        output Start, A_In, B_In, C_In,
`ifdef CLA_SEQ_SUB_EN
        output Op,
`endif
        output Add_Sum, Add_Cout,
        input  Ready, Busy, Done, Sum_Out, C_Out,
        input  Add_A, Add_B, Add_Cin
    );
endinterface

// File: rtl/cla_seq_ctrl.sv
// cla_seq_ctrl
//   Sequences a WORDS x 16-bit addition through one external 16-bit
//   combinational CLA adder, one word per clock, least significant word first.
//   Ports:
//     clock   : single clock, rising edge
//     reset_n : asynchronous active-low reset
//     bus     : cla_seq_ctrl_if.slave (Start/operands in, Ready/Busy/Done,
//               Sum_Out/C_Out out, Add_* to and from the external adder)
//   Optional macro: CLA_SEQ_SUB_EN enables bus.Op; Op=1 computes A-B as
//   A + ~B + 1, so C_Out=1 means no borrow (A >= B).
module cla_seq_ctrl #(
    parameter int WORDS = 4
) (
    input  logic           clock,
    input  logic           reset_n,
    cla_seq_ctrl_if.slave  bus
);
    localparam logic [2:0] LAST = 3'(WORDS - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [16*WORDS-1:0]   a_q, b_q, sum_q;
    logic                  carry_q;
    logic [2:0]            idx_q;
    logic [15:0]           a_word, b_word;
    logic                  init_carry;
`ifdef CLA_SEQ_SUB_EN
    logic                  op_q;
`endif

    assign bus.Sum_Out = sum_q;
    assign bus.C_Out   = carry_q;

`ifdef CLA_SEQ_SUB_EN
    assign init_carry = bus.Op ? 1'b1 : bus.C_In;
`else
    assign init_carry = bus.C_In;
`endif

    always_comb begin
        a_word = '0;
        b_word = '0;
        for (int unsigned w = 0; w < WORDS; w++) begin
            if (idx_q == 3'(w)) begin
                a_word = a_q[w*16 +: 16];
                b_word = b_q[w*16 +: 16];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bus.Ready   = 1'b0;
        bus.Busy    = 1'b0;
        bus.Done    = 1'b0;
        bus.Add_A   = '0;
        bus.Add_B   = '0;
        bus.Add_Cin = 1'b0;
        case (state_q)
            S_IDLE: begin
                bus.Ready = 1'b1;
                if (bus.Start) state_d = S_RUN;
            end
            S_RUN: begin
                bus.Busy    = 1'b1;
                bus.Add_A   = a_word;
`ifdef CLA_SEQ_SUB_EN
                bus.Add_B   = op_q ? ~b_word : b_word;
`else
                bus.Add_B   = b_word;
`endif
                bus.Add_Cin = carry_q;
                if (idx_q == LAST) state_d = S_DONE;
            end
            S_DONE: begin
                bus.Done = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: operands latched on acceptance, one result word per RUN cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
`ifdef CLA_SEQ_SUB_EN
            op_q    <= 1'b0;
`endif
        end else begin
            if (state_q == S_IDLE && bus.Start) begin
                a_q     <= bus.A_In;
                b_q     <= bus.B_In;
                carry_q <= init_carry;
                idx_q   <= '0;
`ifdef CLA_SEQ_SUB_EN
                op_q    <= bus.Op;
`endif
            end else if (state_q == S_RUN) begin
                for (int unsigned w = 0; w < WORDS; w++) begin
                    if (idx_q == 3'(w)) sum_q[w*16 +: 16] <= bus.Add_Sum;
                end
                carry_q <= bus.Add_Cout;
                idx_q   <= idx_q + 3'd1;
            end
        end
    end
endmodule

// File: tb/tb_cla_seq_ctrl.sv
module tb_cla_seq_ctrl;
    localparam int WORDS = 4;
    localparam int W     = 16 * WORDS;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    cla_seq_ctrl_if #(.WORDS(WORDS)) bus ();
    cla_seq_ctrl_if #(.WORDS(1))     bus1 ();

    // External 16-bit adders
    assign {bus.Add_Cout, bus.Add_Sum}   = 17'(bus.Add_A) + 17'(bus.Add_B) + 17'(bus.Add_Cin);
    assign {bus1.Add_Cout, bus1.Add_Sum} = 17'(bus1.Add_A) + 17'(bus1.Add_B) + 17'(bus1.Add_Cin);

    cla_seq_ctrl #(.WORDS(WORDS)) u_dut  (.clock(clock), .reset_n(reset_n), .bus(bus));
    cla_seq_ctrl #(.WORDS(1))     u_dut1 (.clock(clock), .reset_n(reset_n), .bus(bus1));

    int checks = 0;
    int errors = 0;

    function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endfunction

    // ---------------- behavioural model (WORDS-wide instance) -------------
    // age: -1 idle, 0..WORDS-1 working on word 'age', WORDS = result cycle
    int             age = -1;
    logic [128:0]   m_a = '0, m_b = '0;
    logic           m_cin = 1'b0;
    logic [W-1:0]   m_sum = '0;
    logic           m_c = 1'b0;

    function automatic logic [128:0] low(logic [128:0] v, int k);
        return v & ((129'd1 << (16 * k)) - 129'd1);
    endfunction

    always @(posedge clock or negedge reset_n) begin : mdl
        logic [128:0] a, b, f;
        logic [W-1:0] nb;
        logic         c;
        if (!reset_n) begin
            age   <= -1;
            m_sum <= '0;
            m_c   <= 1'b0;
        end else if (age < 0) begin
            if (bus.Start) begin
                nb = ~bus.B_In;
                a  = 129'(bus.A_In);
                b  = 129'(bus.B_In);
                c  = bus.C_In;
`ifdef CLA_SEQ_SUB_EN
                if (bus.Op) begin
                    b = 129'(nb);
                    c = 1'b1;
                end
`endif
                f     = a + b + 129'(c);
                m_a   <= a;
                m_b   <= b;
                m_cin <= c;
                m_sum <= W'(f);
                m_c   <= f[W];
                age   <= 0;
            end
        end else if (age == WORDS) begin
            age <= -1;
        end else begin
            age <= age + 1;
        end
    end

    initial begin : cmp
        logic         busy_e;
        logic [128:0] part;
        forever begin
            @(negedge clock);
            #2;
            busy_e = (age >= 0) && (age < WORDS);
            chk("m_ready", bus.Ready, age < 0);
            chk("m_busy",  bus.Busy,  busy_e);
            chk("m_done",  bus.Done,  age == WORDS);
            if (busy_e) begin
                part = (low(m_a, age) + low(m_b, age) + 129'(m_cin)) >> (16 * age);
                chk("m_add_a",   bus.Add_A,   16'(m_a >> (16 * age)));
                chk("m_add_b",   bus.Add_B,   16'(m_b >> (16 * age)));
                chk("m_add_cin", bus.Add_Cin, part[0]);
            end else begin
                chk("m_add_a_idle",   bus.Add_A,   0);
                chk("m_add_b_idle",   bus.Add_B,   0);
                chk("m_add_cin_idle", bus.Add_Cin, 0);
                chk("m_sum",  bus.Sum_Out, m_sum);
                chk("m_cout", bus.C_Out,   m_c);
            end
        end
    end

    // ---------------- stimulus and literal expectations -------------------
    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic start_op(logic [W-1:0] a, logic [W-1:0] b, logic c, logic op);
        bus.A_In  = a;
        bus.B_In  = b;
        bus.C_In  = c;
`ifdef CLA_SEQ_SUB_EN
        bus.Op    = op;
`endif
        bus.Start = 1'b1;
        step();
        // operands scrambled after acceptance must not matter
        bus.Start = 1'b0;
        bus.A_In  = ~a;
        bus.B_In  = W'({$urandom, $urandom, $urandom, $urandom});
        bus.C_In  = ~c;
`ifdef CLA_SEQ_SUB_EN
        bus.Op    = ~op;
`endif
    endtask

    initial begin : stim
        int rdy, dn;
        bus.Start = 0; bus.A_In = '0; bus.B_In = '0; bus.C_In = 0;
        bus1.Start = 0; bus1.A_In = '0; bus1.B_In = '0; bus1.C_In = 0;
`ifdef CLA_SEQ_SUB_EN
        bus.Op = 0; bus1.Op = 0;
`endif
        repeat (3) step();
        chk("rst_ready", bus.Ready, 1);
        chk("rst_busy",  bus.Busy,  0);
        chk("rst_sum",   bus.Sum_Out, 0);
        reset_n = 1'b1;

        // carry crossing word 0 -> word 1
        start_op(64'hFFFF, 64'h1, 1'b0, 1'b0);
        chk("c31_busy_s1", bus.Busy, 1);
        chk("c31_adda_s1", bus.Add_A, 16'hFFFF);
        step();
        chk("c31_cin_s2", bus.Add_Cin, 1);
        step(); step();
        chk("c31_done_s4", bus.Done, 0);
        step();
        chk("c31_done_s5", bus.Done, 1);
        chk("c31_sum", bus.Sum_Out, 64'h0000_0000_0001_0000);
        chk("c31_cout", bus.C_Out, 0);
        step();
        chk("c31_ready_s6", bus.Ready, 1);

        // full-width carry ripple, Add_A slices in index order
        start_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("c32_adda_w%0d", i), bus.Add_A, 16'hFFFF);
            step();
        end
        chk("c32_sum", bus.Sum_Out, 64'h0);
        chk("c32_cout", bus.C_Out, 1);
        step();

        // second Start while busy is dropped
        start_op(64'h1, 64'h1, 1'b0, 1'b0);
        bus.A_In = 64'h5; bus.B_In = 64'h5; bus.C_In = 1'b0; bus.Start = 1'b1;
        rdy = int'(bus.Ready);
        dn  = 0;
        for (int s = 2; s <= 8; s++) begin
            step();
            if (s == 2) bus.Start = 1'b0;
            if (s <= 5) rdy += int'(bus.Ready);
            dn += int'(bus.Done);
            if (s == 5) chk("c33_sum", bus.Sum_Out, 64'h2);
        end
        chk("c33_ready_low", rdy, 0);
        chk("c33_one_done", dn, 1);

        // reset in the middle of an operation
        start_op(64'h1234_5678_9ABC_DEF0, 64'h1111_2222_3333_4444, 1'b1, 1'b0);
        step();
        reset_n = 1'b0;
        #1;
        chk("c34_busy", bus.Busy, 0);
        chk("c34_ready", bus.Ready, 1);
        chk("c34_sum", bus.Sum_Out, 0);
        chk("c34_cout", bus.C_Out, 0);
        step();
        chk("c34_nodone", bus.Done, 0);
        reset_n = 1'b1;
        start_op(64'h3, 64'h4, 1'b0, 1'b0);
        chk("c34_first_start", bus.Busy, 1);
        repeat (4) step();
        chk("c34_done", bus.Done, 1);
        chk("c34_sum2", bus.Sum_Out, 64'h7);
        step();

`ifdef CLA_SEQ_SUB_EN
        start_op(64'h5, 64'h7, 1'b0, 1'b1);
        repeat (4) step();
        chk("c35_sum_a", bus.Sum_Out, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("c35_cout_a", bus.C_Out, 0);
        step();
        start_op(64'h7, 64'h5, 1'b0, 1'b1);
        repeat (4) step();
        chk("c35_sum_b", bus.Sum_Out, 64'h2);
        chk("c35_cout_b", bus.C_Out, 1);
        step();
`endif

        // single-word instance, back-to-back operations
        bus1.A_In = 16'hFFFF; bus1.B_In = 16'h0001; bus1.C_In = 1'b0; bus1.Start = 1'b1;
        step();
        bus1.Start = 1'b0;
        chk("c36_busy_s1", bus1.Busy, 1);
        step();
        chk("c36_done_s2", bus1.Done, 1);
        chk("c36_sum", bus1.Sum_Out, 16'h0000);
        chk("c36_cout", bus1.C_Out, 1);
        step();
        chk("c36_ready_s3", bus1.Ready, 1);
        bus1.A_In = 16'h1234; bus1.B_In = 16'h4321; bus1.C_In = 1'b1; bus1.Start = 1'b1;
        step();
        bus1.Start = 1'b0;
        chk("c36_b2b_busy", bus1.Busy, 1);
        step();
        chk("c36_b2b_done", bus1.Done, 1);
        chk("c36_b2b_sum", bus1.Sum_Out, 16'h5556);
        chk("c36_b2b_cout", bus1.C_Out, 0);

        // randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
            step();
            if ($urandom_range(199) == 0) begin
                reset_n = 1'b0;
                step();
                reset_n = 1'b1;
            end
            bus.Start = ($urandom_range(2) == 0);
            bus.A_In  = W'({$urandom, $urandom, $urandom, $urandom});
            bus.B_In  = ($urandom_range(3) == 0) ? ~bus.A_In
                                                 : W'({$urandom, $urandom, $urandom, $urandom});
            bus.C_In  = 1'($urandom);
`ifdef CLA_SEQ_SUB_EN
            bus.Op    = 1'($urandom);
`endif
        end
        bus.Start = 1'b0;
        repeat (WORDS + 3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cla_seq_ctrl.md
CLA_SEQ_CTRL -- requirements
Module: cla_seq_ctrl

Interface
REQ-001: Parameter WORDS, default 4, number of 16-bit words per operand; legal range 1-8.
REQ-002: clock  input  1  single clock; all state updates on rising edge.
REQ-003: reset_n  input  1  reset, asynchronous, active-low.
REQ-004: Start  input  1  operation request; accepted only when Ready=1.
REQ-005: A_In  input  16*WORDS  operand A, sampled on accepted Start.
REQ-006: B_In  input  16*WORDS  operand B, sampled on accepted Start.
REQ-007: C_In  input  1  initial carry, sampled on accepted Start.
REQ-008: Ready  output  1  high only in IDLE.
REQ-009: Busy  output  1  high in RUN.
REQ-010: Done  output  1  one-cycle pulse, result valid.
REQ-011: Sum_Out  output  16*WORDS  result, held until next accepted Start.
REQ-012: C_Out  output  1  final carry, held with Sum_Out.
REQ-013: Add_A, Add_B  output  16 each  operand slices to the external 16-bit combinational CLA adder.
REQ-014: Add_Cin  output  1  carry into external adder.
REQ-015: Add_Sum  input  16; Add_Cout  input  1  external adder results, same-cycle combinational.

Function
REQ-016: FSM states IDLE, RUN, DONE; IDLE->RUN on Start&Ready; RUN->DONE when word index = WORDS-1; DONE->IDLE unconditionally.
REQ-017: On accepted Start: latch A_In, B_In; carry register <= C_In; word index <= 0.
REQ-018: In RUN, Add_A/Add_B = latched word[index], Add_Cin = carry register; index 0 = bits 15:0, ascending.
REQ-019: Each RUN cycle edge: Sum_Out word[index] <= Add_Sum; carry register <= Add_Cout; index <= index+1.
REQ-020: Outside RUN, Add_A, Add_B, Add_Cin drive 0.
REQ-021: C_Out = carry register after the last word; Done=1 in DONE only.
REQ-022: Latency: Start accepted at edge t -> RUN for WORDS cycles -> Done high in cycle t+WORDS+1; Ready high again the following cycle.
REQ-023: Start while Ready=0 (RUN or DONE) ignored; no latch, no queueing.
REQ-024: Operand inputs changing after acceptance have no effect on the running operation.
REQ-025: Arithmetic is modulo 2^(16*WORDS); carry out of top word appears only on C_Out.
REQ-026: WORDS=1: exactly one RUN cycle, Done at t+2.

Reset
REQ-027: reset_n low, at any time incl. mid-RUN: state IDLE, Ready=1, Busy=0, Done=0, Sum_Out=0, C_Out=0, carry register=0, index=0, operand registers=0; in-flight operation discarded.
REQ-028: First Start after reset_n deassertion accepted on first rising edge with reset_n=1.

Configuration
REQ-029: Macro CLA_SEQ_SUB_EN: when defined, input Op (1 bit, sampled with Start; 0=add, 1=subtract) exists; for Op=1, Add_B = bitwise inverse of B word, initial carry = 1 (C_In ignored), C_Out = 1 means no borrow (A>=B).
REQ-030: When CLA_SEQ_SUB_EN undefined: no Op port, add only; behaviour per REQ-016..026.

Verification (WORDS=4 unless noted)
REQ-031: A=0x0000_0000_0000_FFFF, B=0x1, C_In=0 -> Sum_Out=0x0000_0000_0001_0000, C_Out=0, Done exactly at t+5, Add_Cin=1 on second RUN cycle.
REQ-032: A=0xFFFF_FFFF_FFFF_FFFF, B=0x0, C_In=1 -> Sum_Out=0x0, C_Out=1; Add_A slices observed 0xFFFF x4 in index order.
REQ-033: Start accepted with A=0x1,B=0x1; second Start at t+2 with A=0x5,B=0x5 -> Sum_Out=0x2, single Done, second request dropped, Ready=0 during t+1..t+5.
REQ-034: reset_n low at t+2 mid-RUN -> immediately Busy=0, Ready=1, Sum_Out=0, no Done; subsequent A=0x3,B=0x4 -> Sum_Out=0x7.
REQ-035: CLA_SEQ_SUB_EN defined: A=0x5,B=0x7,Op=1 -> Sum_Out=0xFFFF_FFFF_FFFF_FFFE, C_Out=0; A=0x7,B=0x5,Op=1 -> Sum_Out=0x2, C_Out=1.
REQ-036: WORDS=1: A=0xFFFF, B=0x0001, C_In=0 -> Sum_Out=0x0000, C_Out=1, Done at t+2; back-to-back Start at t+3 accepted.
